// File: rtl/vga_scan_gen.sv
// Pixel timing and scan-address generator for the 640x480@60 display path.
// Produces scan counters, the 32x32 block address for the map memory, and sync/blank aligned to the RGB pipeline.
module vga_scan_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] x_ptr,
  output logic [9:0] y_ptr,
  output logic [4:0] block_col,
  output logic [3:0] block_row,
  output logic [8:0] block_addr,
  output logic       video_on,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  // Delay-line reset word: {hs, vs, video_on}
  localparam logic [2:0] DLY_RST  = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             pix_en_reg;
  logic             frame_start_reg, frame_start_next;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = div_cnt_reg + 1'b1;
    x_next       = x_reg;
    y_next       = y_reg;
    if (tick) begin
      div_cnt_next = '0;
      if (x_reg == H_LAST) begin
        x_next = '0;
        y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  // Pulse lands in the same cycle the counters become (0,0)
  assign frame_start_next = tick && (x_reg == H_LAST) && (y_reg == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg     <= '0;
      pix_en_reg      <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      pix_en_reg      <= tick;
      x_reg           <= x_next;
      y_reg           <= y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign pix_en      = pix_en_reg;
  assign x_ptr       = x_reg;
  assign y_ptr       = y_reg;
  assign frame_start = frame_start_reg;

  logic       vis;
  logic [4:0] col_raw;
  logic [3:0] row_raw;
  logic [8:0] row_x20;
  logic [8:0] addr_raw;

  assign vis      = (x_reg < H_VIS_C) && (y_reg < V_VIS_C);
  assign col_raw  = x_reg[9:5];
  assign row_raw  = y_reg[8:5];
  // row*20 as row*16 + row*4
  assign row_x20  = {1'b0, row_raw, 4'b0000} + {3'b000, row_raw, 2'b00};
  assign addr_raw = row_x20 + {4'b0000, col_raw};

  assign block_col  = vis ? col_raw  : 5'd0;
  assign block_row  = vis ? row_raw  : 4'd0;
  assign block_addr = vis ? addr_raw : 9'd0;

  logic hs_raw, vs_raw;
  assign hs_raw = ((x_reg >= HS_BEG) && (x_reg < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((y_reg >= VS_BEG) && (y_reg < VS_END)) ? SYNC_POL : ~SYNC_POL;

  logic [2:0] dly_in, dly_out;
  assign dly_in = {hs_raw, vs_raw, vis};

  // Free-running delay (not gated by pix_en) to match the map-read + RGB register latency
  generate
    if (PIPE_LAT == 0) begin : g_pass
      assign dly_out = dly_in;
    end else begin : g_pipe
      logic [2:0] tap [PIPE_LAT+1];
      assign tap[0] = dly_in;
      for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
        logic [2:0] stage_reg;
        always_ff @(posedge clk) begin
          if (rst) stage_reg <= DLY_RST;
          else     stage_reg <= tap[gi];
        end
        assign tap[gi+1] = stage_reg;
      end
      assign dly_out = tap[PIPE_LAT];
    end
  endgenerate

  assign {hs, vs, video_on} = dly_out;

endmodule
